pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the five-stage core (fetch, decode, execute, memory, writeback). It computes the per-stage hold/advance/flush signals for the decode→execute pipeline register and its neighbours. It resolves load-use hazards, multi-cycle execute/memory back-pressure, branch-mispredict redirects and halt. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `CNT_WIDTH`, 32, width of the performance counters.

- `clk_i` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `D_vaild_i` in 1: decode stage holds a valid instruction.
- `D_rs1_i`, `D_rs2_i` in 5 each: decode source register indices.
- `D_use_rs1_i`, `D_use_rs2_i` in 1 each: the decoded instruction reads that source.
- `DD_vaild_i` in 1: decode→execute register holds a valid instruction.
- `DD_load_i` in 1: that instruction is a load (`DD_load_op != 0`).
- `DD_dstE_i` in 5: its destination register.
- `E_ready_i` in 1: execute result is complete this cycle; low during multi-cycle ops.
- `E_redirect_i` in 1: execute resolved a mispredict; meaningful only with `E_ready_i`.
- `M_vaild_i` in 1: memory stage holds a valid instruction.
- `M_ready_i` in 1: memory access is complete this cycle.
- `halt_i` in 1: writeback commits ebreak/ecall.
- `fetch_control_o` out 1: 0 loads a bubble into the fetch→decode register.
- `decode_control_o` out 1: 0 loads a bubble into the decode→execute register.
- `decode_ready_o` out 1: decode may hand its instruction forward.
- `execute_allow_in_o` out 1: execute accepts a new instruction.
- `memory_allow_in_o` out 1: memory accepts a new instruction.
- `fetch_stall_o` out 1: fetch PC and fetch→decode register hold.
- `state_o` out 2: current FSM state.
- `stall_cnt_o` out CNT_WIDTH: count of stall cycles.
- `flush_cnt_o` out CNT_WIDTH: count of redirects.

## Operation
- `memory_allow_in_o = ~M_vaild_i | M_ready_i`. Writeback always accepts.
- `execute_allow_in_o = ~DD_vaild_i | (E_ready_i & memory_allow_in_o)`.
- `load_use = D_vaild_i & DD_vaild_i & DD_load_i & (DD_dstE_i != 0) & ((D_use_rs1_i & D_rs1_i == DD_dstE_i) | (D_use_rs2_i & D_rs2_i == DD_dstE_i))`.
- `redirect_fire = E_redirect_i & DD_vaild_i & E_ready_i & memory_allow_in_o`.
- In RUN:
  - `decode_ready_o = ~load_use`.
  - `decode_control_o = ~((load_use & execute_allow_in_o) | redirect_fire)`. A bubble is inserted only when execute advances; when execute stalls, the register holds.
  - `fetch_control_o = ~redirect_fire`.
  - `fetch_stall_o = ~(decode_ready_o & execute_allow_in_o) & ~redirect_fire`.
- FSM states (encoding in `define.v`): RESET=0, RUN=1, FLUSH=2, HALT=3.
  - RESET → RUN after one cycle.
  - RUN → FLUSH on `redirect_fire`.
  - FLUSH → RUN after one cycle. This squashes the wrong-path fetch still in flight.
  - RUN/FLUSH → HALT on `halt_i`. `halt_i` has priority over `redirect_fire`.
  - HALT is left only by reset.
- In RESET, FLUSH and HALT:
  - `fetch_control_o = 0` and `decode_control_o = 0`.
  - `decode_ready_o = 0`.
  - `fetch_stall_o = 0` in RESET/FLUSH; `fetch_stall_o = 1` in HALT.
  - The allow_in outputs keep their formulas so older instructions drain.
- `stall_cnt_o` increments in RUN when `D_vaild_i & ~(decode_ready_o & execute_allow_in_o)`.
- `flush_cnt_o` increments on `redirect_fire` in RUN.
- Both counters saturate at all-ones and never wrap.

## Timing
- All hazard/flush outputs are combinational from inputs and state; there is zero-cycle latency to the pipeline registers.
- State and counters update on `posedge clk_i`.
- Reset values: `state_o=0` (RESET), `stall_cnt_o=0`, `flush_cnt_o=0`. While `rst_n` is low, the outputs are:
  - `fetch_control_o=0`, `decode_control_o=0`, `decode_ready_o=0`, `fetch_stall_o=0`.
- Reset asserted mid-FLUSH or mid-HALT returns the FSM to RESET immediately (asynchronously).
- Load-use costs exactly 1 bubble when execute is not stalled.
- A redirect costs 2 squashed fetch slots: the redirect cycle plus the FLUSH cycle.
- Load-use and `redirect_fire` in the same cycle: the redirect wins, and `decode_control_o=0`.
- `E_redirect_i` without `E_ready_i` is ignored.

## Structure
- State encodings `CTRL_RESET/RUN/FLUSH/HALT` go in `define.v` as `define` macros.
- One sub-module, `pipe_sat_cnt`: a parameterised saturating counter with enable. It is instantiated twice.
- Hazard logic stays inline.

## Test plan
- Reset release: the first cycle has `state_o=0` and both controls 0; the next cycle has `state_o=1` and both controls 1.
- Load x5 in execute (`DD_load_i=1`, `DD_dstE_i=5`), decode reads `rs1=5`, `E_ready_i=1`:
  - `decode_ready_o=0`, `decode_control_o=0`, `fetch_stall_o=1`, `stall_cnt_o` becomes 1.
  - Repeat with `DD_dstE_i=0`: no stall.
- Same load-use with `E_ready_i=0`:
  - `execute_allow_in_o=0`, `decode_control_o=1` (hold, not bubble).
- `E_redirect_i=1`, `E_ready_i=1`, `DD_vaild_i=1`, memory free:
  - Both controls are 0 this cycle and in the following FLUSH cycle.
  - `flush_cnt_o` becomes 1, then the FSM returns to RUN.
- `M_vaild_i=1`, `M_ready_i=0` with a redirect pending:
  - No flush until `M_ready_i=1`.
  - `memory_allow_in_o=0`, `execute_allow_in_o=0`.
- `halt_i` together with a redirect: `state_o=3` stays until `rst_n` goes low; the counters do not increment. Also preload the counters to all-ones and stall: they stay at all-ones.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings and helpers for the pipeline sequencing controller.
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define CTRL_RESET 2'd0
`define CTRL_RUN   2'd1
`define CTRL_FLUSH 2'd2
`define CTRL_HALT  2'd3
`endif

package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RESET = `CTRL_RESET;
    localparam logic [1:0] ST_RUN   = `CTRL_RUN;
    localparam logic [1:0] ST_FLUSH = `CTRL_FLUSH;
    localparam logic [1:0] ST_HALT  = `CTRL_HALT;

    // True when a source operand is actually read and names the given register.
    function automatic logic src_match(input logic use_src,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module pipe_sat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count enabled events until every bit is set, then stick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: hazard/flush/halt control for the
// decode->execute boundary plus stall and redirect performance counters.
//
// state | meaning
// ------+--------------------------------------------------------------
// RESET | one cycle after reset release; all pipe controls held off
// RUN   | normal operation; load-use and redirect handling active
// FLUSH | one cycle squashing the wrong-path fetch still in flight
// HALT  | ebreak/ecall committed; front end frozen until reset
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 D_vaild_i,
    input  logic [4:0]           D_rs1_i,
    input  logic [4:0]           D_rs2_i,
    input  logic                 D_use_rs1_i,
    input  logic                 D_use_rs2_i,
    input  logic                 DD_vaild_i,
    input  logic                 DD_load_i,
    input  logic [4:0]           DD_dstE_i,
    input  logic                 E_ready_i,
    input  logic                 E_redirect_i,
    input  logic                 M_vaild_i,
    input  logic                 M_ready_i,
    input  logic                 halt_i,
    output logic                 fetch_control_o,
    output logic                 decode_control_o,
    output logic                 decode_ready_o,
    output logic                 execute_allow_in_o,
    output logic                 memory_allow_in_o,
    output logic                 fetch_stall_o,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       load_use;
    logic       redirect_fire;
    logic       in_run;
    logic       stall_en;
    logic       flush_en;

    assign memory_allow_in_o  = ~M_vaild_i | M_ready_i;
    assign execute_allow_in_o = ~DD_vaild_i | (E_ready_i & memory_allow_in_o);

    assign load_use = D_vaild_i & DD_vaild_i & DD_load_i & (DD_dstE_i != 5'd0) &
                      (src_match(D_use_rs1_i, D_rs1_i, DD_dstE_i) |
                       src_match(D_use_rs2_i, D_rs2_i, DD_dstE_i));

    // A redirect only counts once execute finishes and memory can take its result.
    assign redirect_fire = E_redirect_i & DD_vaild_i & E_ready_i & memory_allow_in_o;

    assign in_run  = (state == ST_RUN);
    assign state_o = state;

    // Front-end controls; outside RUN the front end is frozen, and HALT keeps fetch stalled.
    always_comb begin
        decode_ready_o   = 1'b0;
        decode_control_o = 1'b0;
        fetch_control_o  = 1'b0;
        fetch_stall_o    = (state == ST_HALT);
        if (in_run) begin
            decode_ready_o   = ~load_use;
            decode_control_o = ~((load_use & execute_allow_in_o) | redirect_fire);
            fetch_control_o  = ~redirect_fire;
            fetch_stall_o    = ~(~load_use & execute_allow_in_o) & ~redirect_fire;
        end
    end

    // Next-state selection; halt outranks a simultaneous redirect.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET: state_nxt = ST_RUN;
            ST_RUN: begin
                if (halt_i)             state_nxt = ST_HALT;
                else if (redirect_fire) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: state_nxt = halt_i ? ST_HALT : ST_RUN;
            default:  state_nxt = ST_HALT;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state <= ST_RESET;
        else        state <= state_nxt;
    end

    assign stall_en = in_run & D_vaild_i & ~(decode_ready_o & execute_allow_in_o);
    assign flush_en = in_run & redirect_fire & ~halt_i;

    pipe_sat_cnt #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_n),
        .en    (stall_en),
        .count (stall_cnt_o)
    );

    pipe_sat_cnt #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk_i),
        .rst_n (rst_n),
        .en    (flush_en),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed literal checks followed by randomized
// traffic compared every cycle against a behavioural model.
module tb_pipe_ctrl;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          D_vaild_i = 0, D_use_rs1_i = 0, D_use_rs2_i = 0;
    logic [4:0]    D_rs1_i = 0, D_rs2_i = 0, DD_dstE_i = 0;
    logic          DD_vaild_i = 0, DD_load_i = 0, E_ready_i = 1, E_redirect_i = 0;
    logic          M_vaild_i = 0, M_ready_i = 0, halt_i = 0;
    logic          fetch_control_o, decode_control_o, decode_ready_o;
    logic          execute_allow_in_o, memory_allow_in_o, fetch_stall_o;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: 0 reset, 1 run, 2 flush, 3 halt
    int m_state = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipe_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_n(rst_n),
        .D_vaild_i(D_vaild_i), .D_rs1_i(D_rs1_i), .D_rs2_i(D_rs2_i),
        .D_use_rs1_i(D_use_rs1_i), .D_use_rs2_i(D_use_rs2_i),
        .DD_vaild_i(DD_vaild_i), .DD_load_i(DD_load_i), .DD_dstE_i(DD_dstE_i),
        .E_ready_i(E_ready_i), .E_redirect_i(E_redirect_i),
        .M_vaild_i(M_vaild_i), .M_ready_i(M_ready_i), .halt_i(halt_i),
        .fetch_control_o(fetch_control_o), .decode_control_o(decode_control_o),
        .decode_ready_o(decode_ready_o), .execute_allow_in_o(execute_allow_in_o),
        .memory_allow_in_o(memory_allow_in_o), .fetch_stall_o(fetch_stall_o),
        .state_o(state_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        D_vaild_i = 0; D_use_rs1_i = 0; D_use_rs2_i = 0; D_rs1_i = 0; D_rs2_i = 0;
        DD_vaild_i = 0; DD_load_i = 0; DD_dstE_i = 0; E_ready_i = 1; E_redirect_i = 0;
        M_vaild_i = 0; M_ready_i = 0; halt_i = 0;
    endtask

    task automatic load_use_pattern(input logic [4:0] dst, input logic ready);
        idle();
        D_vaild_i = 1; D_use_rs1_i = 1; D_rs1_i = 5'd5;
        DD_vaild_i = 1; DD_load_i = 1; DD_dstE_i = dst; E_ready_i = ready;
    endtask

    task automatic redirect_pattern();
        idle();
        DD_vaild_i = 1; E_ready_i = 1; E_redirect_i = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("async_reset_state", state_o, 0);
        chk("async_reset_fc", fetch_control_o, 0);
        chk("async_reset_dc", decode_control_o, 0);
        chk("async_reset_stall_cnt", stall_cnt_o, 0);
        m_state = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    // Behavioural check of the current cycle; returns the model's verdict on counter events.
    task automatic model_check(output bit stall_ev, output bit flush_ev);
        bit mem_ok, ex_ok, lu, rf, run;
        int e_dr, e_dc, e_fc, e_fs;
        mem_ok = !M_vaild_i || M_ready_i;
        ex_ok  = !DD_vaild_i || (E_ready_i && mem_ok);
        lu = D_vaild_i && DD_vaild_i && DD_load_i && DD_dstE_i != 0 &&
             ((D_use_rs1_i && D_rs1_i == DD_dstE_i) || (D_use_rs2_i && D_rs2_i == DD_dstE_i));
        rf = E_redirect_i && DD_vaild_i && E_ready_i && mem_ok;
        run = (m_state == 1);
        e_dr = run ? int'(!lu) : 0;
        e_dc = run ? int'(!((lu && ex_ok) || rf)) : 0;
        e_fc = run ? int'(!rf) : 0;
        e_fs = run ? int'(!(e_dr == 1 && ex_ok) && !rf) : int'(m_state == 3);
        chk("m_state", state_o, m_state);
        chk("m_mem_allow", memory_allow_in_o, int'(mem_ok));
        chk("m_ex_allow", execute_allow_in_o, int'(ex_ok));
        chk("m_decode_ready", decode_ready_o, e_dr);
        chk("m_decode_control", decode_control_o, e_dc);
        chk("m_fetch_control", fetch_control_o, e_fc);
        chk("m_fetch_stall", fetch_stall_o, e_fs);
        chk("m_stall_cnt", stall_cnt_o, m_stall);
        chk("m_flush_cnt", flush_cnt_o, m_flush);
        stall_ev = run && D_vaild_i && !(e_dr == 1 && ex_ok);
        flush_ev = run && rf && !halt_i;
        case (m_state)
            0: m_state = 1;
            1: m_state = halt_i ? 3 : (rf ? 2 : 1);
            2: m_state = halt_i ? 3 : 1;
            default: m_state = 3;
        endcase
    endtask

    // Step one clock with model bookkeeping; inputs already driven after a negedge.
    task automatic step();
        bit se, fe;
        #1;
        model_check(se, fe);
        @(posedge clk);
        if (se && m_stall < SAT) m_stall++;
        if (fe && m_flush < SAT) m_flush++;
        @(negedge clk);
    endtask

    initial begin
        bit se, fe;
        int halted;
        idle();
        // reset release
        #2;
        chk("rst_state", state_o, 0);
        chk("rst_fc", fetch_control_o, 0);
        chk("rst_dc", decode_control_o, 0);
        chk("rst_dr", decode_ready_o, 0);
        chk("rst_fs", fetch_stall_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_flush_cnt", flush_cnt_o, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        #1;
        chk("rel_state0", state_o, 0);
        chk("rel_fc0", fetch_control_o, 0);
        chk("rel_dc0", decode_control_o, 0);
        @(negedge clk); #1;
        chk("rel_state1", state_o, 1);
        chk("rel_fc1", fetch_control_o, 1);
        chk("rel_dc1", decode_control_o, 1);
        m_state = 1;

        // load-use with execute advancing
        load_use_pattern(5'd5, 1'b1); #1;
        chk("lu_dr", decode_ready_o, 0);
        chk("lu_dc", decode_control_o, 0);
        chk("lu_fs", fetch_stall_o, 1);
        @(negedge clk); #1;
        chk("lu_stall_cnt", stall_cnt_o, 1);
        load_use_pattern(5'd0, 1'b1); #1;
        chk("lu0_dr", decode_ready_o, 1);
        chk("lu0_dc", decode_control_o, 1);
        chk("lu0_fs", fetch_stall_o, 0);
        @(negedge clk); #1;
        chk("lu0_stall_cnt", stall_cnt_o, 1);

        // load-use while execute stalls: hold, not bubble
        load_use_pattern(5'd5, 1'b0); #1;
        chk("lus_ex_allow", execute_allow_in_o, 0);
        chk("lus_dc", decode_control_o, 1);
        @(negedge clk); #1;
        chk("lus_stall_cnt", stall_cnt_o, 2);

        // redirect: two squashed slots then back to run
        redirect_pattern(); #1;
        chk("rd_fc", fetch_control_o, 0);
        chk("rd_dc", decode_control_o, 0);
        @(negedge clk); idle(); #1;
        chk("rd_state_flush", state_o, 2);
        chk("rd_fc_flush", fetch_control_o, 0);
        chk("rd_dc_flush", decode_control_o, 0);
        chk("rd_flush_cnt", flush_cnt_o, 1);
        @(negedge clk); #1;
        chk("rd_state_run", state_o, 1);

        // redirect blocked by busy memory
        redirect_pattern(); M_vaild_i = 1; M_ready_i = 0; #1;
        chk("mb_mem_allow", memory_allow_in_o, 0);
        chk("mb_ex_allow", execute_allow_in_o, 0);
        chk("mb_fc", fetch_control_o, 1);
        @(negedge clk); #1;
        chk("mb_state", state_o, 1);
        chk("mb_flush_cnt", flush_cnt_o, 1);
        M_ready_i = 1; #1;
        chk("mb_fc_go", fetch_control_o, 0);
        @(negedge clk); idle(); #1;
        chk("mb_state_flush", state_o, 2);
        chk("mb_flush_cnt2", flush_cnt_o, 2);
        @(negedge clk);

        // halt together with a redirect
        redirect_pattern(); halt_i = 1;
        @(negedge clk); #1;
        chk("h_state", state_o, 3);
        chk("h_flush_cnt", flush_cnt_o, 2);
        load_use_pattern(5'd5, 1'b1); E_redirect_i = 1; #1;
        chk("h_fs", fetch_stall_o, 1);
        chk("h_dc", decode_control_o, 0);
        repeat (4) @(negedge clk);
        #1;
        chk("h_state_hold", state_o, 3);
        chk("h_stall_cnt", stall_cnt_o, 2);
        chk("h_flush_cnt_hold", flush_cnt_o, 2);
        do_reset();
        idle();
        @(negedge clk);

        // saturation: drive both counters to all-ones and keep going
        load_use_pattern(5'd5, 1'b1);
        repeat (SAT + 4) @(negedge clk);
        #1;
        chk("sat_stall_cnt", stall_cnt_o, SAT);
        redirect_pattern();
        repeat (2 * SAT + 6) @(negedge clk);
        #1;
        chk("sat_flush_cnt", flush_cnt_o, SAT);
        load_use_pattern(5'd5, 1'b1); E_redirect_i = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("sat_stall_hold", stall_cnt_o, SAT);
        chk("sat_flush_hold", flush_cnt_o, SAT);

        // randomized phase against the model
        do_reset();
        idle();
        halted = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 199) == 0 || halted > 12) begin
                do_reset();
                halted = 0;
            end
            D_vaild_i    = $urandom_range(0, 3) != 0;
            D_rs1_i      = 5'($urandom_range(0, 3));
            D_rs2_i      = 5'($urandom_range(0, 3));
            D_use_rs1_i  = $urandom_range(0, 1);
            D_use_rs2_i  = $urandom_range(0, 1);
            DD_vaild_i   = $urandom_range(0, 3) != 0;
            DD_load_i    = $urandom_range(0, 1);
            DD_dstE_i    = 5'($urandom_range(0, 3));
            E_ready_i    = $urandom_range(0, 3) != 0;
            E_redirect_i = $urandom_range(0, 4) == 0;
            M_vaild_i    = $urandom_range(0, 1);
            M_ready_i    = $urandom_range(0, 2) != 0;
            halt_i       = $urandom_range(0, 79) == 0;
            if (m_state == 3) halted++;
            step();
        end
        // one last sample without advancing
        #1;
        model_check(se, fe);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
